// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, frame configuration and received-data signals of uart_rx
`timescale 1ns/1ps
interface uart_rx_if #(parameter int DATA_WIDTH = 8);
    logic                  RX_IN;
    logic [5:0]            Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Par_Err;
    logic                  Stp_Err;
    modport master (output RX_IN, Prescale, PAR_EN, PAR_TYP, input P_DATA, Data_Valid, Par_Err, Stp_Err);
    modport slave (input RX_IN, Prescale, PAR_EN, PAR_TYP, output P_DATA, Data_Valid, Par_Err, Stp_Err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 3-sample majority vote, optional parity and stop check
`timescale 1ns/1ps
module uart_rx #(parameter int DATA_WIDTH = 8) (
    input logic     CLK,
    input logic     RST,
    uart_rx_if.slave bus
);
    localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state_q, state_d;
    logic s1_q, s2_q;
    logic [5:0] cnt_q, cnt_d, pres_q, pres_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
    logic [1:0] samp_q, samp_d;
    logic bit_q, bit_d, par_en_q, par_en_d, par_typ_q, par_typ_d, perr_q, perr_d;
    logic dv_q, dv_d, pe_q, pe_d, se_q, se_d;
    logic rx_s, vote, at_s0, at_s1, at_vote, at_pe, at_end;
    logic [5:0] half;
    assign rx_s    = s2_q;
    assign half    = {1'b0, pres_q[5:1]};
    assign at_s0   = cnt_q == half - 6'd1;
    assign at_s1   = cnt_q == half;
    assign at_vote = cnt_q == half + 6'd1;
    assign at_pe   = cnt_q == half + 6'd2;
    assign at_end  = cnt_q == pres_q - 6'd1;
    // third sample is the live synchronized value, so the vote lands in a flop at P/2+2
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign bus.P_DATA     = data_q;
    assign bus.Data_Valid = dv_q;
    assign bus.Par_Err    = pe_q;
    assign bus.Stp_Err    = se_q;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 6'd1;
        pres_d    = pres_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        samp_d    = {at_s1 ? rx_s : samp_q[1], at_s0 ? rx_s : samp_q[0]};
        bit_d     = bit_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        perr_d    = perr_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = rx_s ? 6'd0 : 6'd1;
                if (!rx_s) begin
                    state_d   = START;
                    pres_d    = bus.Prescale;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                    perr_d    = 1'b0;
                end
            end
            START: begin
                if (at_vote && vote) begin
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                end else if (at_end) begin
                    state_d = DATA;
                    cnt_d   = 6'd0;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (at_vote) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
                if (at_end) begin
                    cnt_d = 6'd0;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_vote) bit_d = vote;
                if (at_pe && (bit_q != (^shift_q ^ par_typ_q))) begin
                    pe_d   = 1'b1;
                    perr_d = 1'b1;
                end
                if (at_end) begin
                    state_d = STOP;
                    cnt_d   = 6'd0;
                end
            end
            STOP: begin
                if (at_vote) begin
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                    se_d    = !vote;
                    dv_d    = vote && !perr_q;
                    data_d  = (vote && !perr_q) ? shift_q : data_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            cnt_q     <= '0;
            pres_q    <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            samp_q    <= '0;
            bit_q     <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            perr_q    <= 1'b0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= bus.RX_IN;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            pres_q    <= pres_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            perr_q    <= perr_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives UART frames and checks outcomes and pulse timing against a frame-level model
`timescale 1ns/1ps
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst_n;
    int cyc = 0;
    int asserts = 0;
    int fails = 0;
    int dv_cyc[$];
    logic [7:0] dv_dat[$];
    int pe_cyc[$];
    int se_cyc[$];
    logic [7:0] exp_pdata = 8'h00;

    uart_rx_if #(.DATA_WIDTH(8)) bus();
    uart_rx #(.DATA_WIDTH(8)) dut (.CLK(clk), .RST(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.Data_Valid) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(bus.P_DATA);
        end
        if (bus.Par_Err) pe_cyc.push_back(cyc);
        if (bus.Stp_Err) se_cyc.push_back(cyc);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // rx_s goes low 2 cycles after the start-bit drive, so frame timing is s+2+offset
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                              input bit flip, input bit stp, output int s);
        logic [10:0] bits;
        int n;
        bus.Prescale = 6'(p);
        bus.PAR_EN = pen;
        bus.PAR_TYP = ptyp;
        n = pen ? 11 : 10;
        bits = pen ? {stp, ^d ^ ptyp ^ flip, d, 1'b0} : {1'b0, stp, d, 1'b0};
        s = cyc;
        for (int i = 0; i < n; i++) begin
            bus.RX_IN = bits[i];
            repeat (p) @(negedge clk);
        end
        bus.RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        asserts++; if (bus.P_DATA !== 8'h00) begin fails++; $display("FAIL reset_pdata: got %h expected 00", bus.P_DATA); end
        asserts++; if (bus.Data_Valid !== 1'b0) begin fails++; $display("FAIL reset_dv: got %b expected 0", bus.Data_Valid); end
        asserts++; if (bus.Par_Err !== 1'b0) begin fails++; $display("FAIL reset_pe: got %b expected 0", bus.Par_Err); end
        asserts++; if (bus.Stp_Err !== 1'b0) begin fails++; $display("FAIL reset_se: got %b expected 0", bus.Stp_Err); end
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_basic();
        int dv0 = dv_cyc.size(), pe0 = pe_cyc.size(), se0 = se_cyc.size(), s;
        send_frame(8'hA5, 8, 0, 0, 0, 1, s);
        idle(16);
        exp_pdata = 8'hA5;
        asserts++; if (dv_cyc.size() - dv0 !== 1) begin fails++; $display("FAIL basic_dv_count: got %0d expected 1", dv_cyc.size() - dv0); end
        asserts++; if (dv_cyc.size() <= dv0 || dv_cyc[dv0] !== s + 80) begin fails++; $display("FAIL basic_dv_time: got cycle %0d expected %0d", dv_cyc.size() > dv0 ? dv_cyc[dv0] : -1, s + 80); end
        asserts++; if (bus.P_DATA !== exp_pdata) begin fails++; $display("FAIL basic_pdata: got %h expected %h", bus.P_DATA, exp_pdata); end
        asserts++; if (pe_cyc.size() + se_cyc.size() - pe0 - se0 !== 0) begin fails++; $display("FAIL basic_errs: got %0d error pulses expected 0", pe_cyc.size() + se_cyc.size() - pe0 - se0); end
    endtask

    task automatic test_parity();
        int dv0 = dv_cyc.size(), pe0 = pe_cyc.size(), se0 = se_cyc.size(), s1, s2;
        send_frame(8'h3C, 16, 1, 0, 0, 1, s1);
        idle(32);
        exp_pdata = 8'h3C;
        asserts++; if (dv_cyc.size() <= dv0 || dv_cyc[dv0] !== s1 + 2 + 10*16 + 10 || dv_dat[dv0] !== 8'h3C) begin fails++; $display("FAIL parity_ok_dv: got %0d pulses expected one at %0d with 3c", dv_cyc.size() - dv0, s1 + 172); end
        send_frame(8'h3C, 16, 1, 0, 1, 1, s2);
        idle(32);
        asserts++; if (dv_cyc.size() - dv0 !== 1) begin fails++; $display("FAIL parity_bad_dv: got %0d pulses expected 1", dv_cyc.size() - dv0); end
        asserts++; if (pe_cyc.size() - pe0 !== 1) begin fails++; $display("FAIL parity_bad_count: got %0d expected 1", pe_cyc.size() - pe0); end
        asserts++; if (pe_cyc.size() <= pe0 || pe_cyc[pe0] !== s2 + 2 + 9*16 + 11) begin fails++; $display("FAIL parity_bad_time: got %0d expected %0d", pe_cyc.size() > pe0 ? pe_cyc[pe0] : -1, s2 + 157); end
        asserts++; if (bus.P_DATA !== exp_pdata) begin fails++; $display("FAIL parity_pdata_hold: got %h expected %h", bus.P_DATA, exp_pdata); end
        asserts++; if (se_cyc.size() - se0 !== 0) begin fails++; $display("FAIL parity_se: got %0d expected 0", se_cyc.size() - se0); end
    endtask

    task automatic test_stop();
        int dv0 = dv_cyc.size(), pe0 = pe_cyc.size(), se0 = se_cyc.size(), s;
        send_frame(8'h81, 32, 0, 0, 0, 0, s);
        idle(96);
        asserts++; if (se_cyc.size() - se0 !== 1) begin fails++; $display("FAIL stop_count: got %0d expected 1", se_cyc.size() - se0); end
        asserts++; if (se_cyc.size() <= se0 || se_cyc[se0] !== s + 2 + 9*32 + 18) begin fails++; $display("FAIL stop_time: got %0d expected %0d", se_cyc.size() > se0 ? se_cyc[se0] : -1, s + 308); end
        asserts++; if (dv_cyc.size() - dv0 + pe_cyc.size() - pe0 !== 0) begin fails++; $display("FAIL stop_other: got %0d pulses expected 0", dv_cyc.size() - dv0 + pe_cyc.size() - pe0); end
        asserts++; if (bus.P_DATA !== exp_pdata) begin fails++; $display("FAIL stop_pdata_hold: got %h expected %h", bus.P_DATA, exp_pdata); end
    endtask

    task automatic test_glitch();
        int dv0 = dv_cyc.size(), pe0 = pe_cyc.size(), se0 = se_cyc.size(), s;
        bus.Prescale = 6'd8;
        bus.PAR_EN = 1'b0;
        bus.RX_IN = 1'b0;
        idle(3);
        bus.RX_IN = 1'b1;
        idle(20);
        asserts++; if (dv_cyc.size() - dv0 + pe_cyc.size() - pe0 + se_cyc.size() - se0 !== 0) begin fails++; $display("FAIL glitch_flags: got %0d pulses expected 0", dv_cyc.size() - dv0 + pe_cyc.size() - pe0 + se_cyc.size() - se0); end
        send_frame(8'h5A, 8, 0, 0, 0, 1, s);
        idle(16);
        exp_pdata = 8'h5A;
        asserts++; if (dv_cyc.size() - dv0 !== 1 || dv_cyc[dv0] !== s + 80) begin fails++; $display("FAIL glitch_next_dv: got %0d pulses expected one at %0d", dv_cyc.size() - dv0, s + 80); end
        asserts++; if (bus.P_DATA !== exp_pdata) begin fails++; $display("FAIL glitch_next_pdata: got %h expected %h", bus.P_DATA, exp_pdata); end
    endtask

    task automatic test_back_to_back();
        int dv0 = dv_cyc.size(), pe0 = pe_cyc.size(), se0 = se_cyc.size();
        int s[3];
        logic [7:0] d[3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) send_frame(d[i], 8, 1, 1, 0, 1, s[i]);
        idle(24);
        exp_pdata = 8'h33;
        asserts++; if (dv_cyc.size() - dv0 !== 3) begin fails++; $display("FAIL b2b_count: got %0d expected 3", dv_cyc.size() - dv0); end
        for (int i = 0; i < 3; i++) begin
            asserts++;
            if (dv_cyc.size() <= dv0 + i || dv_dat[dv0 + i] !== d[i] || dv_cyc[dv0 + i] !== s[i] + 2 + 10*8 + 6) begin
                fails++; $display("FAIL b2b_frame%0d: got %h at %0d expected %h at %0d", i, dv_cyc.size() > dv0 + i ? dv_dat[dv0 + i] : 8'hxx, dv_cyc.size() > dv0 + i ? dv_cyc[dv0 + i] : -1, d[i], s[i] + 88);
            end
        end
        asserts++; if (pe_cyc.size() - pe0 + se_cyc.size() - se0 !== 0) begin fails++; $display("FAIL b2b_errs: got %0d expected 0", pe_cyc.size() - pe0 + se_cyc.size() - se0); end
    endtask

    task automatic test_reset_midframe();
        int dv0 = dv_cyc.size(), pe0 = pe_cyc.size(), se0 = se_cyc.size(), sa, s;
        fork
            send_frame(8'h96, 8, 0, 0, 0, 1, sa);
            begin
                idle(5*8 + 4);
                rst_n = 1'b0;
                #1;
                asserts++; if ({bus.P_DATA, bus.Data_Valid, bus.Par_Err, bus.Stp_Err} !== 11'h0) begin fails++; $display("FAIL midreset_outputs: got %h/%b%b%b expected 00/000", bus.P_DATA, bus.Data_Valid, bus.Par_Err, bus.Stp_Err); end
            end
        join
        idle(4);
        rst_n = 1'b1;
        idle(4);
        exp_pdata = 8'h00;
        send_frame(8'hC3, 8, 0, 0, 0, 1, s);
        idle(16);
        exp_pdata = 8'hC3;
        asserts++; if (dv_cyc.size() - dv0 !== 1 || dv_cyc[dv0] !== s + 80) begin fails++; $display("FAIL midreset_dv: got %0d pulses expected one at %0d", dv_cyc.size() - dv0, s + 80); end
        asserts++; if (bus.P_DATA !== exp_pdata) begin fails++; $display("FAIL midreset_pdata: got %h expected %h", bus.P_DATA, exp_pdata); end
        asserts++; if (pe_cyc.size() - pe0 + se_cyc.size() - se0 !== 0) begin fails++; $display("FAIL midreset_errs: got %0d expected 0", pe_cyc.size() - pe0 + se_cyc.size() - se0); end
    endtask

    // outcome per frame: bad stop -> Stp_Err; bad parity -> Par_Err; only a clean frame updates P_DATA
    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            int dv0 = dv_cyc.size(), pe0 = pe_cyc.size(), se0 = se_cyc.size(), s, p, n;
            logic [7:0] d = 8'($urandom);
            bit pen = 1'($urandom), ptyp = 1'($urandom);
            bit flip = pen && ($urandom_range(0, 3) == 0);
            bit stp = $urandom_range(0, 5) != 0;
            bit ok = stp && !flip;
            p = 8 + 2 * $urandom_range(0, 12);
            n = pen ? 11 : 10;
            send_frame(d, p, pen, ptyp, flip, stp, s);
            idle(3 * p);
            if (ok) exp_pdata = d;
            asserts++; if (dv_cyc.size() - dv0 !== int'(ok) || (ok && dv_cyc[dv0] !== s + 2 + (n-1)*p + p/2 + 2)) begin fails++; $display("FAIL rand%0d_dv: got %0d pulses expected %0d at %0d", k, dv_cyc.size() - dv0, ok, s + 2 + (n-1)*p + p/2 + 2); end
            asserts++; if (pe_cyc.size() - pe0 !== int'(flip) || (flip && pe_cyc[pe0] !== s + 2 + 9*p + p/2 + 3)) begin fails++; $display("FAIL rand%0d_pe: got %0d pulses expected %0d", k, pe_cyc.size() - pe0, flip); end
            asserts++; if (se_cyc.size() - se0 !== int'(!stp) || (!stp && se_cyc[se0] !== s + 2 + (n-1)*p + p/2 + 2)) begin fails++; $display("FAIL rand%0d_se: got %0d pulses expected %0d", k, se_cyc.size() - se0, !stp); end
            asserts++; if (bus.P_DATA !== exp_pdata) begin fails++; $display("FAIL rand%0d_pdata: got %h expected %h", k, bus.P_DATA, exp_pdata); end
        end
    endtask

    initial begin
        bus.RX_IN = 1'b1;
        bus.Prescale = 6'd8;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_stop();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_WIDTH, 8, number of data bits per frame; all frame-length figures below assume 8.
REQ-002 Port: CLK  input  1  oversampling clock, Prescale cycles per bit.
REQ-003 Port: RST  input  1  reset, asynchronous, active-low.
REQ-004 Port: RX_IN  input  1  serial line, idle high, driven by a UART_TX-compatible transmitter.
REQ-005 Port: Prescale  input  6  CLK cycles per bit; legal values are even numbers in 8..32.
REQ-006 Port: PAR_EN  input  1  1 = parity bit present between data and stop bits.
REQ-007 Port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 Port: P_DATA  output  DATA_WIDTH  last correctly received data byte.
REQ-009 Port: Data_Valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-010 Port: Par_Err  output  1  one-cycle pulse on parity mismatch.
REQ-011 Port: Stp_Err  output  1  one-cycle pulse on stop bit sampled low.

Function
REQ-012 The frame format SHALL be: start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit, and one stop bit (1).
REQ-013 RX_IN SHALL pass through a 2-flop synchronizer; all decisions below use the synchronized value (rx_s).
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-015 The FSM SHALL leave IDLE when rx_s = 0; that cycle is edge count 0 of the start bit.
REQ-016 Prescale, PAR_EN and PAR_TYP SHALL be captured on the IDLE->START transition and held constant for the whole frame.
REQ-017 An edge counter SHALL count 0..Prescale-1 per bit and wrap to 0 on entering the next bit; a bit counter SHALL track data bit index 0..DATA_WIDTH-1.
REQ-018 Each bit SHALL be sampled at edge counts P/2-1, P/2 and P/2+1; the bit value SHALL be the majority vote of the three samples, registered at count P/2+2.
REQ-019 START: if the voted start bit is 1, the FSM SHALL treat it as a glitch, return to IDLE at count P/2+2, and raise no flags; otherwise it SHALL go to DATA after count P-1.
REQ-020 DATA: the voted bit SHALL shift into a receive register (LSB first); after bit DATA_WIDTH-1 completes at count P-1, the FSM SHALL go to PARITY if PAR_EN = 1, else to STOP.
REQ-021 PARITY: the voted bit SHALL be compared with the XOR of the received data (inverted if PAR_TYP = 1); on mismatch, Par_Err SHALL pulse for 1 cycle at count P/2+3; the FSM SHALL always go to STOP after count P-1.
REQ-022 STOP: at count P/2+2, a voted stop bit of 0 SHALL pulse Stp_Err for one cycle.
REQ-023 STOP: at count P/2+2, if the stop bit is 1 and the frame had no parity error, P_DATA SHALL be loaded and Data_Valid SHALL pulse in that same cycle.
REQ-024 STOP: the FSM SHALL return to IDLE at count P/2+2 regardless of outcome, so a start bit immediately following the stop bit is accepted.
REQ-025 P_DATA SHALL hold its value across errored frames, glitches and idle periods.
REQ-026 Data_Valid, Par_Err and Stp_Err SHALL never be high for more than one consecutive cycle.
REQ-027 Data_Valid and Stp_Err SHALL never be high in the same cycle.
REQ-028 Behaviour with illegal Prescale values is unspecified.

Reset
REQ-029 On RST low, asynchronously: FSM to IDLE; counters, receive register and P_DATA to 0; Data_Valid, Par_Err and Stp_Err to 0; synchronizer flops to 1.
REQ-030 A reset mid-frame SHALL abort the frame with no flags raised; after release, the receiver SHALL wait for a fresh falling edge on rx_s.

Verification
REQ-031 Prescale=8, PAR_EN=0, byte 0xA5 -> P_DATA=0xA5; Data_Valid pulses exactly once, 78 cycles after the first rx_s-low cycle; no error flags.
REQ-032 Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x3C with correct parity 0 -> P_DATA=0x3C, Data_Valid=1; then the same byte with parity bit 1 -> Par_Err pulses once, no Data_Valid, P_DATA stays 0x3C.
REQ-033 Prescale=32, PAR_EN=0, byte 0x81 with stop bit forced 0 -> Stp_Err pulses once, no Data_Valid, P_DATA unchanged.
REQ-034 A 3-cycle low glitch on idle RX_IN at Prescale=8 -> no flags, FSM back in IDLE; a following valid frame 0x5A is received correctly.
REQ-035 Back-to-back frames 0x11, 0x22, 0x33 with no idle gap (Prescale=8, PAR_EN=1, PAR_TYP=1) -> three Data_Valid pulses with P_DATA 0x11, 0x22, 0x33.
REQ-036 RST asserted during data bit 4 of a frame -> all outputs 0 immediately; the next full frame 0xC3 is received correctly.
